a2d_arbiter: RTL and testbench
==============================

// Module: a2d_arbiter
// PURPOSE
//  Shares the single A2D_intf SPI converter between NREQ requesters (slide-pot scanner, battery
//  monitor, etc.). Round-robin arbitration, drives strt_cnv/chnnl toward A2D_intf, waits for
//  cnv_cmplt, returns the 12-bit result to the winning requester with a one-cycle done pulse.
// PARAMETERS
//  NREQ         4     number of requesters (2..8)
//  TIMEOUT_CYC  4095  max WAIT cycles before abort (used only with A2D_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst_n      in   1          reset, asynchronous, active-low
//  req        in   NREQ       level request per requester; held until its done pulse
//  req_chnnl  in   3*NREQ     requester i channel in bits [3i+2:3i]
//  gnt        out  NREQ       one-hot grant, high from START through DONE
//  done       out  NREQ       one-cycle pulse to granted requester when rd_data valid
//  rd_data    out  12         captured conversion result
//  err        out  1          one-cycle pulse with done on timeout abort (0 if macro off)
//  busy       out  1          high whenever state != IDLE
//  strt_cnv   out  1          to A2D_intf: one-cycle start pulse
//  chnnl      out  3          to A2D_intf: channel, stable from START until return to IDLE
//  cnv_cmplt  in   1          from A2D_intf: conversion complete
//  res        in   12         from A2D_intf: conversion result
// BEHAVIOUR
//  - Reset values: gnt=0, done=0, rd_data=0, err=0, busy=0, strt_cnv=0, chnnl=0, state=IDLE,
//    rr pointer last=NREQ-1 (so requester 0 wins first). All outputs registered.
//  - States: IDLE -> START -> WAIT -> DONE -> IDLE.
//  - IDLE: if |req, winner = first set req scanning last+1, last+2, ... (wrap at NREQ);
//    register gnt one-hot and chnnl=req_chnnl[winner]; go START. No req: stay IDLE.
//  - START: strt_cnv=1 for exactly this cycle; go WAIT.
//  - WAIT: cnv_cmplt sampled only here (a cnv_cmplt high in IDLE/START is ignored);
//    on cnv_cmplt=1: rd_data<=res, go DONE.
//  - DONE: done[winner]=1 one cycle; last<=winner; gnt cleared on exit; go IDLE.
//  - Latency: req seen in IDLE cycle N -> strt_cnv cycle N+2, done = cnv_cmplt cycle + 2.
//  - Back-to-back: minimum 4 cycles per conversion plus A2D time; IDLE always lasts >=1 cycle.
//  - Fairness: a requester keeping req high after done is re-queued behind all other pending
//    requesters; no requester waits more than NREQ-1 conversions.
//  - req dropped after grant: conversion still completes, done still pulses, no abort.
//  - req_chnnl change after grant: ignored (chnnl latched in IDLE).
//  - rd_data holds last value until the next DONE; not cleared between conversions.
//  - Async reset mid-operation: immediate return to reset values; strt_cnv low; no done issued.
// CONFIGURATION
//  - A2D_ARB_TIMEOUT_EN defined: 12-bit counter cleared on WAIT entry, increments each WAIT
//    cycle; reaching TIMEOUT_CYC without cnv_cmplt -> DONE with err=1 and done[winner]=1,
//    rd_data unchanged; rr pointer advances as normal. cnv_cmplt on the terminal cycle wins
//    (normal completion, err=0).
//  - Not defined: no counter, WAIT waits indefinitely, err tied 0.
// TESTING
//  - Reset, req=0001 ch0=3'd5 -> strt_cnv 2 cycles later, chnnl=5; cnv_cmplt w/ res=12'hA5C
//    -> done=0001 next+1 cycle, rd_data=12'hA5C, gnt cleared after.
//  - req=1111 held continuously -> grant order 0,1,2,3,0 with one strt_cnv per grant.
//  - last=1, req=1001 -> requester 3 granted before 0; then 0.
//  - cnv_cmplt pulsed during START and IDLE -> ignored, FSM stays in WAIT until real complete.
//  - rst_n low during WAIT -> all outputs 0 same cycle; after release req=0010 restarts cleanly.
//  - Macro on, TIMEOUT_CYC=16, no cnv_cmplt -> done+err on 16th WAIT cycle, rd_data unchanged;
//    macro off same stimulus -> busy stays high, no done.

Source files
------------

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin arbiter sharing one A2D_intf converter among NREQ requesters.
// Each granted requester gets one conversion on its channel. The 12-bit result and a
// one-cycle done pulse are returned to that requester.
// Optional feature macro: A2D_ARB_TIMEOUT_EN. It aborts a WAIT that lasts TIMEOUT_CYC cycles.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NREQ]          level request per requester, held until its done pulse
//   req_chnnl[3*NREQ]  requester i channel in bits [3i+2:3i]
//   gnt[NREQ]          one-hot grant, START through DONE
//   done[NREQ]         one-cycle completion pulse to the granted requester
//   rd_data[12]        last captured conversion result
//   err                timeout abort flag, pulses with done (tied 0 without the macro)
//   busy               arbiter not idle
//   strt_cnv, chnnl    start pulse and channel toward A2D_intf
//   cnv_cmplt, res     completion and result from A2D_intf
module a2d_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     req_chnnl,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [11:0]           rd_data,
  output logic                  err,
  output logic                  busy,
  output logic                  strt_cnv,
  output logic [2:0]            chnnl,
  input  logic                  cnv_cmplt,
  input  logic [11:0]           res
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CHW = 3;
  localparam int unsigned DW  = 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   win_q, win_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [DW-1:0]   rd_nxt;
  logic [CHW-1:0]  chnnl_nxt;
  logic            err_nxt, busy_nxt, strt_nxt;

  logic [CHW-1:0]  ch_arr [NREQ];
  logic            found_c;
  logic [IW-1:0]   pick_c;
  int unsigned     scan_idx;

`ifdef A2D_ARB_TIMEOUT_EN
  localparam int unsigned CW = 12;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            tmo, tmo_nxt;
`else
  logic            unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYC);
`endif

  // Split the packed channel bus into one entry per requester
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      ch_arr[i] = req_chnnl[CHW*i +: CHW];
    end
  end

  // Round-robin scan starting just after the last served requester
  always_comb begin
    found_c  = 1'b0;
    pick_c   = '0;
    scan_idx = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = 32'(last) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found_c && req[IW'(scan_idx)]) begin
        found_c = 1'b1;
        pick_c  = IW'(scan_idx);
      end
    end
  end

  // Next-state and next-output logic; every output is registered one cycle behind its state
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    win_nxt   = win_q;
    gnt_nxt   = gnt;
    chnnl_nxt = chnnl;
    rd_nxt    = rd_data;
    strt_nxt  = 1'b0;
    done_nxt  = '0;
    err_nxt   = 1'b0;
`ifdef A2D_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    tmo_nxt   = tmo;
`endif
    case (state)
      IDLE: begin
        if (found_c) begin
          win_nxt   = pick_c;
          gnt_nxt   = NREQ'(1) << pick_c;
          chnnl_nxt = ch_arr[pick_c];
          state_nxt = START;
        end
      end
      START: begin
        strt_nxt  = 1'b1;
        state_nxt = WAIT;
`ifdef A2D_ARB_TIMEOUT_EN
        cnt_nxt   = '0;
        tmo_nxt   = 1'b0;
`endif
      end
      WAIT: begin
        if (cnv_cmplt) begin
          rd_nxt    = res;
          state_nxt = DONE;
        end
`ifdef A2D_ARB_TIMEOUT_EN
        // A completion on the terminal cycle takes priority over the abort
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
`endif
      end
      DONE: begin
        done_nxt  = gnt;
        gnt_nxt   = '0;
        last_nxt  = win_q;
        state_nxt = IDLE;
`ifdef A2D_ARB_TIMEOUT_EN
        err_nxt   = tmo;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IW'(NREQ - 1);
      win_q    <= '0;
      gnt      <= '0;
      done     <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
`ifdef A2D_ARB_TIMEOUT_EN
      cnt      <= '0;
      tmo      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      win_q    <= win_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      rd_data  <= rd_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      strt_cnv <= strt_nxt;
      chnnl    <= chnnl_nxt;
`ifdef A2D_ARB_TIMEOUT_EN
      cnt      <= cnt_nxt;
      tmo      <= tmo_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: directed and randomized checks of a2d_arbiter against a round-robin reference model.
module tb_a2d_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_chnnl;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [11:0]       rd_data;
  logic              err;
  logic              busy;
  logic              strt_cnv;
  logic [2:0]        chnnl;
  logic              cnv_cmplt;
  logic [11:0]       res;

  int tests;
  int fails;
  int last_m;          // model round-robin pointer
  logic [11:0] rd_m;   // model of the held result

  a2d_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_chnnl (req_chnnl),
    .gnt       (gnt),
    .done      (done),
    .rd_data   (rd_data),
    .err       (err),
    .busy      (busy),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first asserted requester after the last one served, wrapping
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (lst + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion, started from an IDLE sample point with req already driven
  task automatic conv(input string tag, input int dly, input logic [11:0] r,
                      input bit spurious, input bit drop);
    int w;
    logic [2:0] ch;
    logic [NREQ-1:0] oh;
    w  = rr_pick(req, last_m);
    ch = req_chnnl[3*w +: 3];
    oh = NREQ'(1) << w;
    if (spurious) cnv_cmplt = 1'b1;
    tick();
    chk({tag, ":gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ":busy"}, 32'(busy), 32'd1);
    chk({tag, ":strt_early"}, 32'(strt_cnv), 32'd0);
    if (drop) begin
      req       = '0;
      req_chnnl = 12'($urandom);
    end
    tick();
    if (spurious) cnv_cmplt = 1'b0;
    chk({tag, ":strt"}, 32'(strt_cnv), 32'd1);
    chk({tag, ":chnnl"}, 32'(chnnl), 32'(ch));
    repeat (dly) tick();
    if (dly > 0) begin
      chk({tag, ":wait_done"}, 32'(done), 32'd0);
      chk({tag, ":wait_busy"}, 32'(busy), 32'd1);
      chk({tag, ":wait_strt"}, 32'(strt_cnv), 32'd0);
    end
    res       = r;
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    res       = 12'($urandom);
    rd_m      = r;
    chk({tag, ":rd_data"}, 32'(rd_data), 32'(r));
    chk({tag, ":done_early"}, 32'(done), 32'd0);
    tick();
    chk({tag, ":done"}, 32'(done), 32'(oh));
    chk({tag, ":gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, ":busy_clr"}, 32'(busy), 32'd0);
    chk({tag, ":err"}, 32'(err), 32'd0);
    last_m = w;
  endtask

  initial begin
    int w;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_chnnl = '0;
    cnv_cmplt = 1'b0;
    res       = '0;
    last_m    = NREQ - 1;
    rd_m      = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst:gnt", 32'(gnt), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:rd_data", 32'(rd_data), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:strt", 32'(strt_cnv), 32'd0);
    chk("rst:chnnl", 32'(chnnl), 32'd0);
    rst_n = 1'b1;
    tick();

    // All requesting continuously: order 0,1,2,3,0
    req       = 4'b1111;
    req_chnnl = {3'd7, 3'd6, 3'd1, 3'd2};
    for (int i = 0; i < 5; i++) begin
      chk("rr:order", 32'(rr_pick(req, last_m)), 32'(i % NREQ));
      conv("rr", 1, 12'($urandom), 1'b0, 1'b0);
    end
    req = '0;
    tick();

    // Single requester 0 on channel 5
    req       = 4'b0001;
    req_chnnl = {3'd0, 3'd0, 3'd0, 3'd5};
    conv("t1", 2, 12'hA5C, 1'b0, 1'b0);
    req = '0;
    tick();
    chk("t1:idle_busy", 32'(busy), 32'd0);
    chk("t1:rd_hold", 32'(rd_data), 32'hA5C);

    // Completion strobes in IDLE and START are ignored
    req       = 4'b0100;
    req_chnnl = {3'd1, 3'd3, 3'd4, 3'd2};
    conv("spur", 3, 12'h3C1, 1'b1, 1'b1);
    tick();

    // Long WAIT without completion
    req       = 4'b0010;
    req_chnnl = {3'd0, 3'd0, 3'd6, 3'd0};
    w = rr_pick(req, last_m);
    tick();
    tick();
    chk("hang:strt", 32'(strt_cnv), 32'd1);
    req = '0;
`ifdef A2D_ARB_TIMEOUT_EN
    repeat (15) tick();
    chk("tmo:pre_done", 32'(done), 32'd0);
    chk("tmo:pre_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("tmo:done", 32'(done), 32'(NREQ'(1) << w));
    chk("tmo:err", 32'(err), 32'd1);
    chk("tmo:rd_data", 32'(rd_data), 32'(rd_m));
    chk("tmo:gnt", 32'(gnt), 32'd0);
    last_m = w;
`else
    repeat (30) tick();
    chk("hang:busy", 32'(busy), 32'd1);
    chk("hang:done", 32'(done), 32'd0);
    chk("hang:gnt", 32'(gnt), 32'(NREQ'(1) << w));
    chk("hang:err", 32'(err), 32'd0);
    res       = 12'h777;
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    tick();
    chk("hang:done_late", 32'(done), 32'(NREQ'(1) << w));
    chk("hang:rd_data", 32'(rd_data), 32'h777);
    rd_m   = 12'h777;
    last_m = w;
`endif
    tick();

    // Asynchronous reset while in WAIT
    req       = 4'b1000;
    req_chnnl = {3'd3, 3'd0, 3'd0, 3'd0};
    tick();
    tick();
    chk("arst:strt_before", 32'(strt_cnv), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst:strt", 32'(strt_cnv), 32'd0);
    chk("arst:gnt", 32'(gnt), 32'd0);
    chk("arst:busy", 32'(busy), 32'd0);
    chk("arst:chnnl", 32'(chnnl), 32'd0);
    chk("arst:rd_data", 32'(rd_data), 32'd0);
    req    = '0;
    last_m = NREQ - 1;
    rd_m   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst:done", 32'(done), 32'd0);

    // Restart with requester 1, then pointer at 1 with 1001: 3 before 0
    req       = 4'b0010;
    req_chnnl = {3'd4, 3'd0, 3'd2, 3'd1};
    conv("rst1", 1, 12'h123, 1'b0, 1'b0);
    req = 4'b1001;
    chk("ptr:first", 32'(rr_pick(req, last_m)), 32'd3);
    conv("ptr3", 0, 12'h456, 1'b0, 1'b0);
    conv("ptr0", 2, 12'h789, 1'b0, 1'b0);
    req = '0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      req       = 4'($urandom_range(1, 15));
      req_chnnl = 12'($urandom);
      conv("rand", int'($urandom_range(0, 5)), 12'($urandom), 1'b0, 1'($urandom));
    end
    req = '0;
    tick();
    chk("end:busy", 32'(busy), 32'd0);
    chk("end:rd_hold", 32'(rd_data), 32'(rd_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
